// File: rtl/math_adder_ripplecarry_pkg.sv
// Shared constants and the golden arithmetic model for the math adder library.
package math_adder_pkg;

    localparam int MATH_ADDER_DEFAULT_N = 4;

    // Reference result of a + b + ci at n+1 bits; operands above bit n-1 are ignored.
    function automatic logic [64:0] math_adder_golden(
        input logic [63:0] a,
        input logic [63:0] b,
        input logic        ci,
        input int unsigned n
    );
        logic [64:0] mask;
        mask = (65'd1 << n) - 65'd1;
        return ({1'b0, a} & mask) + ({1'b0, b} & mask) + {64'd0, ci};
    endfunction

endpackage

// File: rtl/math_adder_ripplecarry_fulladder.sv
// One-bit full-adder cell; the ripple-carry chain is built from these.
module math_adder_fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/math_adder_ripplecarry.sv
// Registered N-bit ripple-carry adder: {co, s} <= a + b + ci one cycle after sampling.
// Define MATH_ADDER_RIPPLECARRY_OVF_EN to add the registered signed-overflow output ovf.
module math_adder_ripplecarry
    import math_adder_pkg::*;
#(
    parameter int N = MATH_ADDER_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
`ifdef MATH_ADDER_RIPPLECARRY_OVF_EN
    ,
    output logic         ovf
`endif
);

    // No handshake: every cycle presents a new operand pair and every cycle's result is valid.
    logic [N:0]   c;
    logic [N-1:0] sum_c;

    assign c[0] = ci;

    for (genvar i = 0; i < N; i++) begin : g_cell
        math_adder_fulladder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum_c[i]),
            .co (c[i+1])
        );
    end

`ifdef MATH_ADDER_RIPPLECARRY_OVF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s   <= '0;
            co  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            s   <= sum_c;
            co  <= c[N];
            // Carry into and out of the sign bit disagree exactly on signed overflow.
            ovf <= c[N] ^ c[N-1];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s  <= '0;
            co <= 1'b0;
        end else begin
            s  <= sum_c;
            co <= c[N];
        end
    end
`endif

endmodule

// File: tb/tb_math_adder_ripplecarry.sv
// Directed and random checks of the registered ripple-carry adder at N = 4, 1 and 8.
module tb_math_adder_ripplecarry;
    import math_adder_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] a4, b4, s4;
    logic       ci4, co4;
    logic [0:0] a1, b1, s1;
    logic       ci1, co1;
    logic [7:0] a8, b8, s8;
    logic       ci8, co8;
`ifdef MATH_ADDER_RIPPLECARRY_OVF_EN
    logic       ovf4, ovf1, ovf8;
`endif

    int vectors    = 0;
    int miscompares = 0;

    logic [4:0] exp_q4[$];
    logic [1:0] exp_q1[$];
    logic [8:0] exp_q8[$];

    math_adder_ripplecarry #(.N(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .ci(ci4), .s(s4), .co(co4)
`ifdef MATH_ADDER_RIPPLECARRY_OVF_EN
        , .ovf(ovf4)
`endif
    );

    math_adder_ripplecarry #(.N(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .ci(ci1), .s(s1), .co(co1)
`ifdef MATH_ADDER_RIPPLECARRY_OVF_EN
        , .ovf(ovf1)
`endif
    );

    math_adder_ripplecarry #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .ci(ci8), .s(s8), .co(co8)
`ifdef MATH_ADDER_RIPPLECARRY_OVF_EN
        , .ovf(ovf8)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers
    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        a4  = a;
        b4  = b;
        ci4 = ci;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive4(4'hF, 4'hF, 1'b1);
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if ({co4, s4} !== 5'd0) begin
                miscompares++;
                $display("FAIL reset_n4 cycle %0d: got %h, expected 00", k, {co4, s4});
            end
            vectors++;
            if ({co1, s1} !== 2'd0 || {co8, s8} !== 9'd0) begin
                miscompares++;
                $display("FAIL reset_n1_n8 cycle %0d: got n1=%h n8=%h, expected 0", k, {co1, s1}, {co8, s8});
            end
        end
        a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
    endtask

    // New inputs are applied before checking the previous result, so a result that
    // appears without the register stage is caught.
    task automatic test_exhaustive();
        logic [4:0] exp;
        rst_n = 1'b1;
        for (int idx = 0; idx <= 256; idx++) begin
            if (idx < 256) begin
                drive4(4'(idx >> 4), 4'(idx & 15), 1'b0);
                exp_q4.push_back(5'(idx >> 4) + 5'(idx & 15));
            end
            #1;
            if (idx > 0) begin
                exp = exp_q4.pop_front();
                vectors++;
                if ({co4, s4} !== exp) begin
                    miscompares++;
                    $display("FAIL exhaustive pair %0d: got co=%b s=%0d, expected co=%b s=%0d",
                             idx - 1, co4, s4, exp[4], exp[3:0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_carry_in();
        drive4(4'd0, 4'd0, 1'b1);
        tick();
        drive4(4'd15, 4'd0, 1'b1);
        #1;
        vectors++;
        if (s4 !== 4'd1 || co4 !== 1'b0) begin
            miscompares++;
            $display("FAIL carry_in_0_0_1: got co=%b s=%0d, expected co=0 s=1", co4, s4);
        end
        tick();
        drive4(4'd0, 4'd0, 1'b0);
        #1;
        vectors++;
        if (s4 !== 4'd0 || co4 !== 1'b1) begin
            miscompares++;
            $display("FAIL carry_in_full_ripple: got co=%b s=%0d, expected co=1 s=0", co4, s4);
        end
    endtask

    task automatic test_max_wrap_reset();
        drive4(4'd15, 4'd15, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (s4 !== 4'd15 || co4 !== 1'b1) begin
            miscompares++;
            $display("FAIL max_wrap: got co=%b s=%0d, expected co=1 s=15", co4, s4);
        end
        tick();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (s4 !== 4'd0 || co4 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_stream: got co=%b s=%0d, expected co=0 s=0", co4, s4);
        end
        // First edge out of reset registers the inputs present at that edge.
        drive4(4'd9, 4'd8, 1'b0);
        tick();
        drive4(4'd0, 4'd0, 1'b0);
        #1;
        vectors++;
        if (s4 !== 4'd1 || co4 !== 1'b1) begin
            miscompares++;
            $display("FAIL first_after_reset: got co=%b s=%0d, expected co=1 s=1", co4, s4);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] va[3] = '{4'd7, 4'd8, 4'd3};
        logic [3:0] vb[3] = '{4'd1, 4'd8, 4'd2};
        logic [3:0] es[3] = '{4'd8, 4'd0, 4'd5};
        logic       ec[3] = '{1'b0, 1'b1, 1'b0};
        logic       eo[3] = '{1'b1, 1'b1, 1'b0};
        drive4(va[0], vb[0], 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k < 2) drive4(va[k+1], vb[k+1], 1'b0);
            #1;
            vectors++;
            if (s4 !== es[k] || co4 !== ec[k]) begin
                miscompares++;
                $display("FAIL overflow_sum %0d: got co=%b s=%0d, expected co=%b s=%0d",
                         k, co4, s4, ec[k], es[k]);
            end
`ifdef MATH_ADDER_RIPPLECARRY_OVF_EN
            vectors++;
            if (ovf4 !== eo[k]) begin
                miscompares++;
                $display("FAIL overflow_flag %0d: got ovf=%b, expected ovf=%b", k, ovf4, eo[k]);
            end
`else
            if (eo[k] === 1'bx) $display("unreachable");
`endif
        end
    endtask

    task automatic test_width_sweep();
        logic [1:0] e1;
        logic [8:0] e8;
        for (int idx = 0; idx <= 1000; idx++) begin
            if (idx < 1000) begin
                a1  = 1'($urandom_range(0, 1));
                b1  = 1'($urandom_range(0, 1));
                ci1 = 1'($urandom_range(0, 1));
                a8  = 8'($urandom_range(0, 255));
                b8  = 8'($urandom_range(0, 255));
                ci8 = 1'($urandom_range(0, 1));
                exp_q1.push_back(2'(math_adder_golden({63'd0, a1}, {63'd0, b1}, ci1, 1)));
                exp_q8.push_back(9'(math_adder_golden({56'd0, a8}, {56'd0, b8}, ci8, 8)));
            end
            #1;
            if (idx > 0) begin
                e1 = exp_q1.pop_front();
                e8 = exp_q8.pop_front();
                vectors++;
                if ({co1, s1} !== e1) begin
                    miscompares++;
                    $display("FAIL sweep_n1 %0d: got %b, expected %b", idx - 1, {co1, s1}, e1);
                end
                vectors++;
                if ({co8, s8} !== e8) begin
                    miscompares++;
                    $display("FAIL sweep_n8 %0d: got %h, expected %h", idx - 1, {co8, s8}, e8);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive4(4'd0, 4'd0, 1'b0);
        a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
        #2;
        test_reset();
        test_exhaustive();
        test_carry_in();
        test_max_wrap_reset();
        test_overflow();
        test_width_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
